// File: rtl/gb_host_arbiter.sv
// Two-master arbiter for the single ghostbus host port.
// Accepts one transaction at a time from either requester (round-robin on
// contention), issues one registered write or read strobe, waits the fixed
// read latency, and returns the sampled read data to the requester that won.
module gb_host_arbiter #(
    parameter int AW = 24,
    parameter int DW = 32,
    parameter int RD = 8
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    input  logic          r0_valid,
    input  logic          r0_write,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ready,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_valid,
    input  logic          r1_write,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ready,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // The counter runs RD-1 .. 0 in WAIT so the sample lands RD cycles after the strobe.
    localparam logic [7:0] CNT_LOAD = 8'(RD - 1);

    state_t        state_q,   state_d;
    logic [7:0]    cnt_q,     cnt_d;
    logic          prio_q,    prio_d;
    logic          owner_q,   owner_d;
    logic          write_q,   write_d;
    logic [AW-1:0] gb_addr_q, gb_addr_d;
    logic [DW-1:0] gb_wdata_q, gb_wdata_d;
    logic          gb_wen_q,  gb_wen_d;
    logic          gb_rstb_q, gb_rstb_d;
    logic [DW-1:0] rdata0_q,  rdata0_d;
    logic [DW-1:0] rdata1_q,  rdata1_d;

    logic          grant0;
    logic          grant1;

    // Grant is combinational in IDLE only; a contested request goes to prio.
    always_comb begin
        grant0 = (state_q == S_IDLE) & r0_valid & (~r1_valid | ~prio_q);
        grant1 = (state_q == S_IDLE) & r1_valid & (~r0_valid |  prio_q);
    end

    // Next-state and datapath: latch the winning request, sequence strobe/wait/response.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        write_d    = write_q;
        gb_addr_d  = gb_addr_q;
        gb_wdata_d = gb_wdata_q;
        gb_wen_d   = 1'b0;
        gb_rstb_d  = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant0 | grant1) begin
                    owner_d    = grant1;
                    write_d    = grant1 ? r1_write : r0_write;
                    gb_addr_d  = grant1 ? r1_addr  : r0_addr;
                    gb_wdata_d = grant1 ? r1_wdata : r0_wdata;
                    prio_d     = ~grant1;
                    gb_wen_d   = write_d;
                    gb_rstb_d  = ~write_d;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (write_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    if (owner_q) rdata1_d = gb_rdata;
                    else         rdata0_d = gb_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            write_q    <= 1'b0;
            gb_addr_q  <= '0;
            gb_wdata_q <= '0;
            gb_wen_q   <= 1'b0;
            gb_rstb_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            write_q    <= write_d;
            gb_addr_q  <= gb_addr_d;
            gb_wdata_q <= gb_wdata_d;
            gb_wen_q   <= gb_wen_d;
            gb_rstb_q  <= gb_rstb_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign r0_ready  = grant0;
    assign r1_ready  = grant1;
    assign r0_rvalid = (state_q == S_RESP) & ~owner_q;
    assign r1_rvalid = (state_q == S_RESP) &  owner_q;
    assign r0_rdata  = rdata0_q;
    assign r1_rdata  = rdata1_q;
    assign gb_addr   = gb_addr_q;
    assign gb_wdata  = gb_wdata_q;
    assign gb_wen    = gb_wen_q;
    assign gb_rstb   = gb_rstb_q;
    assign busy      = (state_q != S_IDLE);

endmodule
